// File: rtl/afe_pkg.sv
// afe_pkg: shared AFE4403 SPI constants - data_part tags, LED control register address, capture FSM states.
package afe_pkg;
   localparam logic [1:0] ADDER_DATA = 2'b00;
   localparam logic [1:0] H_DATA     = 2'b01;
   localparam logic [1:0] M_DATA     = 2'b10;
   localparam logic [1:0] L_DATA     = 2'b11;
   localparam logic [7:0] LED_CTRL_ADDR = 8'h22;
   typedef enum logic [2:0] {S_IDLE, S_GET_H, S_GET_M, S_GET_L, S_DONE} state_t;
endpackage

// File: rtl/afe_rd_timeout.sv
// afe_rd_timeout: W-bit frame timer; i_clr zeroes, i_run counts, o_expire while running at LIMIT-1.
// Ports: div_clk clock, rst sync active-low reset, i_clr clear, i_run count enable, o_expire limit reached.
module afe_rd_timeout #(
   parameter int unsigned LIMIT = 40000,
   parameter int unsigned W     = 16
) (
   input  logic div_clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_run,
   output logic o_expire
);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);
   logic [W-1:0] r_cnt;
   always_ff @(posedge div_clk)
      if (!rst || i_clr) r_cnt <= '0;
      else if (i_run && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
   assign o_expire = i_run && (r_cnt == LAST);
endmodule

// File: rtl/afe_rd_capture.sv
// afe_rd_capture: assembles AFE4403 read frames (adder/h/m/l) from SPI bytes and checks LED readback.
// Ports: div_clk clock; rst sync active-low reset; cap_en read window; spi_done/data_part/spi_rx_data byte in;
//   exp_led1/exp_led2 last written LED values; reg_addr/reg_data/data_valid captured frame;
//   led1_rb/led2_rb/rb_match/rb_err LED readback; frame_err order/timeout/abort; busy frame in progress;
//   err_cnt saturating error count, present only when AFE_RD_ERRCNT_EN is defined.
module afe_rd_capture
   import afe_pkg::*;
#(
   parameter logic [7:0]  LED_REG_ADDR = LED_CTRL_ADDR,
   parameter int unsigned TIMEOUT      = 40000,
   parameter int unsigned TO_W         = 16
) (
   input  logic        div_clk,
   input  logic        rst,
   input  logic        cap_en,
   input  logic        spi_done,
   input  logic [1:0]  data_part,
   input  logic [7:0]  spi_rx_data,
   input  logic [7:0]  exp_led1,
   input  logic [7:0]  exp_led2,
   output logic [7:0]  reg_addr,
   output logic [23:0] reg_data,
   output logic        data_valid,
   output logic [7:0]  led1_rb,
   output logic [7:0]  led2_rb,
   output logic        rb_match,
   output logic        rb_err,
   output logic        frame_err,
`ifdef AFE_RD_ERRCNT_EN
   output logic [7:0]  err_cnt,
`endif
   output logic        busy
);
   state_t      r_state, w_next;
   logic [7:0]  r_addr;
   logic [15:0] r_hm;
   logic        w_acc, w_in_get, w_expire, w_start, w_good, w_err, w_done, w_led, w_hit;
   logic [1:0]  w_want;
   assign w_acc    = cap_en && spi_done;
   assign w_in_get = (r_state == S_GET_H) || (r_state == S_GET_M) || (r_state == S_GET_L);
   assign w_want   = (r_state == S_GET_H) ? H_DATA : (r_state == S_GET_M) ? M_DATA : L_DATA;
   assign w_done   = w_good && (r_state == S_GET_L);
   assign w_led    = r_addr == LED_REG_ADDR;
   assign w_hit    = (r_hm[7:0] == exp_led1) && (spi_rx_data == exp_led2);
   assign busy     = r_state != S_IDLE;
   afe_rd_timeout #(.LIMIT(TIMEOUT), .W(TO_W)) u_timeout (
      .div_clk (div_clk),
      .rst     (rst),
      .i_clr   (w_start),
      .i_run   (w_in_get),
      .o_expire(w_expire)
   );
   // Timeout and a closed window take priority over any byte arriving in the same cycle.
   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_good  = 1'b0;
      w_err   = 1'b0;
      case (r_state)
         S_IDLE: if (w_acc) begin
            w_start = data_part == ADDER_DATA;
            w_err   = !w_start;
            w_next  = w_start ? S_GET_H : S_IDLE;
         end
         S_GET_H, S_GET_M, S_GET_L:
            if (w_expire || !cap_en) begin
               w_err  = 1'b1;
               w_next = S_IDLE;
            end else if (spi_done) begin
               w_good  = data_part == w_want;
               w_start = data_part == ADDER_DATA;
               w_err   = !w_good;
               w_next  = w_good ? ((r_state == S_GET_H) ? S_GET_M : (r_state == S_GET_M) ? S_GET_L : S_DONE)
                                : (w_start ? S_GET_H : S_IDLE);
            end
         default: w_next = S_IDLE;
      endcase
   end
   // Frame results register on the edge that takes the l byte, so they are visible during DONE.
   always_ff @(posedge div_clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_hm       <= '0;
         reg_addr   <= '0;
         reg_data   <= '0;
         data_valid <= 1'b0;
         led1_rb    <= '0;
         led2_rb    <= '0;
         rb_match   <= 1'b0;
         rb_err     <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         r_state    <= w_next;
         data_valid <= w_done;
         frame_err  <= w_err;
         rb_match   <= w_done && w_led && w_hit;
         rb_err     <= w_done && w_led && !w_hit;
         if (w_start) r_addr <= spi_rx_data;
         if (w_good && r_state == S_GET_H) r_hm[15:8] <= spi_rx_data;
         if (w_good && r_state == S_GET_M) r_hm[7:0] <= spi_rx_data;
         if (w_done) begin
            reg_addr <= r_addr;
            reg_data <= {r_hm, spi_rx_data};
         end
         if (w_done && w_led) begin
            led1_rb <= r_hm[7:0];
            led2_rb <= spi_rx_data;
         end
      end
   end
`ifdef AFE_RD_ERRCNT_EN
   logic [7:0] r_err_cnt;
   always_ff @(posedge div_clk)
      if (!rst) r_err_cnt <= '0;
      else if ((rb_err || frame_err) && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
   assign err_cnt = r_err_cnt;
`endif
endmodule

// File: doc/afe_rd_capture.md
Name: afe_rd_capture

Overview:
- Receive-side counterpart of the brightness-adjust command generator: captures MISO bytes from the SPI byte engine during AFE4403 read frames.
- Assembles each frame into an 8-bit address plus a 24-bit register word, following the adder/h/m/l sequence tagged by data_part.
- When the frame addresses the LED control register, extracts the LED1/LED2 readback and checks it against the values last written.
- Sits between the SPI engine and the brightness/control logic, in the div_clk domain.

Parameters:
- LED_REG_ADDR, 8'h22, address whose readback is checked against expected LED values.
- TIMEOUT, 40000, div_clk cycles allowed from first byte to last byte of a frame before abort.
- TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- div_clk  in  1  system (divided) clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- cap_en  in  1  read window open (SPI_READ bit set); bytes are ignored while low.
- spi_done  in  1  one-cycle pulse: byte transfer complete, spi_rx_data valid.
- data_part  in  2  byte tag: 00 adder, 01 h, 10 m, 11 l.
- spi_rx_data  in  8  received MISO byte.
- exp_led1  in  8  last LED1 value written.
- exp_led2  in  8  last LED2 value written.
- reg_addr  out  8  captured address of the last complete frame.
- reg_data  out  24  captured data of the last complete frame ({h,m,l}).
- data_valid  out  1  one-cycle pulse: reg_addr/reg_data updated.
- led1_rb  out  8  reg_data[15:8] of the last LED_REG_ADDR frame.
- led2_rb  out  8  reg_data[7:0] of the last LED_REG_ADDR frame.
- rb_match  out  1  one-cycle pulse: LED frame matched exp_led1/exp_led2.
- rb_err  out  1  one-cycle pulse: LED frame mismatched.
- frame_err  out  1  one-cycle pulse: out-of-order tag or timeout.
- busy  out  1  high from the first accepted byte until the frame completes or aborts.

Behaviour:
- Reset (rst=0 at a clock edge): all outputs 0, FSM to IDLE, timeout counter 0. Reset mid-frame discards the partial frame silently, with no frame_err.
- A byte is accepted only on cycles where cap_en=1 and spi_done=1.
- FSM states and transitions:
  - IDLE: an accepted byte with tag 00 latches the address and goes to GET_H. A byte with any other tag pulses frame_err and stays in IDLE.
  - GET_H: expects tag 01; latches byte to data[23:16].
  - GET_M: expects tag 10; latches byte to data[15:8].
  - GET_L: expects tag 11; latches byte to data[7:0] and goes to DONE.
  - DONE: one cycle. Updates reg_addr/reg_data and pulses data_valid.
    - If address == LED_REG_ADDR: updates led1_rb/led2_rb in the same cycle. Pulses rb_match if both bytes equal exp_led1/exp_led2 (sampled in DONE), else pulses rb_err.
    - Returns to IDLE.
- Wrong tag in GET_H/GET_M/GET_L: pulse frame_err.
  - If the wrong tag is 00, treat that byte as a new frame start: latch address, go to GET_H.
  - Otherwise go to IDLE.
- cap_en falling while in GET_*: abort to IDLE, pulse frame_err.
- Timeout:
  - Counter clears on the first byte and increments each cycle in GET_*.
  - When it reaches TIMEOUT-1: abort to IDLE, pulse frame_err.
  - A byte accepted in the same cycle as the timeout is dropped; timeout wins.
- Latency: data_valid, rb_match and rb_err assert exactly 1 cycle after the spi_done carrying tag 11.
- Output timing: outputs are registered. rb_match and rb_err are mutually exclusive and never assert for non-LED addresses. data_valid, rb_match, rb_err and frame_err are never held longer than 1 cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: AFE_RD_ERRCNT_EN.
- Defined: adds output err_cnt[7:0], a saturating count of rb_err and frame_err pulses (at most one increment per cycle). It holds at 8'hFF and clears only on reset.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package afe_pkg holds:
  - data_part encodings ADDER_DATA/H_DATA/M_DATA/L_DATA (2'b00..2'b11).
  - LED_CTRL_ADDR 8'h22.
  - FSM state encodings.
- Natural sub-module afe_rd_timeout: a TO_W-bit timer with clear/run/expire, reusable by the write path.

Test Plan:
- Frame with tags 00/01/10/11 and bytes 22,00,14,14, exp 14/14 -> 1 cycle after last spi_done: data_valid=1, reg_data=24'h001414, led1_rb=14, led2_rb=14, rb_match=1.
- Same frame, bytes 22,00,15,14, exp 14/14 -> rb_err=1, rb_match=0, led1_rb=15.
- Frame with address 01, data A1B2C3 -> data_valid=1, reg_data=A1B2C3; rb_match, rb_err, led*_rb unchanged.
- Tag sequence 00,01,00,01,10,11 with address bytes 05 then 22 -> one frame_err, then a single valid frame with reg_addr=22.
- Bytes 00 and 01 accepted, then no spi_done for 40000 cycles -> frame_err at count 39999, busy falls; a subsequent full frame captures correctly.
- rst=0 asserted after the h byte, then a full frame -> no frame_err; only the second frame is reported. With AFE_RD_ERRCNT_EN, 300 forced mismatches -> err_cnt=FF.
